fp_round_norm: RTL and testbench

- Rounding/normalisation stage of the single-precision FP datapath.
- Sits directly upstream of the 24-bit incrementer inc1 and consumes its result.
- Takes a normalised (or denormal) 24-bit significand plus guard/round/sticky bits, and decides the round-up bit that drives inc1.cin.
- Renormalises on inc1.cout, detects overflow, and packs an IEEE-754 binary32 word.
- Two-stage elastic pipeline with valid/ready handshakes.

---
 rtl/fp_round_norm.sv | 146 ++++++++++++++
 tb/tb_fp_round_norm.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fp_round_norm.sv
`default_nettype none
// ============================================================================
// Module   : fp_round_norm (with helper inc1)
// Purpose  : Two-stage elastic round/renormalise/pack stage for binary32.
// Revision : 1.0 - initial release
// ============================================================================

module inc1 #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {{W{1'b0}}, cin};
endmodule

module fp_round_norm #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W-1:0] in_mant,
  input  logic [2:0]       in_grs,
  input  logic [1:0]       in_rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_inexact,
  output logic             out_overflow
);
  localparam logic [1:0]       c_rm_rne  = 2'b00;
  localparam logic [1:0]       c_rm_rtz  = 2'b01;
  localparam logic [1:0]       c_rm_rup  = 2'b10;
  localparam logic [1:0]       c_rm_rdn  = 2'b11;
  localparam logic [MAN_W-1:0] c_hidden  = {1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EXP_W-1:0] c_exp_one = {{(EXP_W-1){1'b0}}, 1'b1};

  logic             r_s1_valid, r_s1_sign, r_s1_up, r_s1_inexact, r_s1_special;
  logic [EXP_W-1:0] r_s1_exp;
  logic [MAN_W-1:0] r_s1_mant;
  logic             r_s2_valid, r_inexact, r_overflow;
  logic [31:0]      r_result;

  logic             w_s1_adv, w_s2_adv;
  logic             w_g, w_r, w_s, w_any, w_in_special, w_up;
  logic [MAN_W-1:0] w_inc_sum, w_mant;
  logic             w_inc_cout;
  logic [EXP_W-1:0] w_exp;
  logic             w_ovf;
  logic [31:0]      w_result;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign out_result   = r_result;
  assign out_inexact  = r_inexact;
  assign out_overflow = r_overflow;

  // Round-up decision
  assign {w_g, w_r, w_s} = in_grs;
  assign w_any        = w_g | w_r | w_s;
  assign w_in_special = &in_exp;

  always_comb begin
    w_up = 1'b0;
    case (in_rm)
      c_rm_rne: w_up = w_g & (w_r | w_s | in_mant[0]);
      c_rm_rtz: w_up = 1'b0;
      c_rm_rup: w_up = !in_sign & w_any;
      c_rm_rdn: w_up = in_sign & w_any;
      default:  w_up = 1'b0;
    endcase
    if (w_in_special) w_up = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_sign    <= 1'b0;
      r_s1_exp     <= '0;
      r_s1_mant    <= '0;
      r_s1_up      <= 1'b0;
      r_s1_inexact <= 1'b0;
      r_s1_special <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign    <= in_sign;
        r_s1_exp     <= in_exp;
        r_s1_mant    <= in_mant;
        r_s1_up      <= w_up;
        r_s1_inexact <= w_any & !w_in_special;
        r_s1_special <= w_in_special;
      end
    end
  end

  inc1 #(.W(MAN_W)) u_inc1 (
    .a    (r_s1_mant),
    .cin  (r_s1_up),
    .sum  (w_inc_sum),
    .cout (w_inc_cout)
  );

  // Renormalise: carry-out shifts the exponent, a denormal reaching the hidden bit becomes normal
  always_comb begin
    w_mant = w_inc_sum;
    w_exp  = r_s1_exp;
    if (w_inc_cout) begin
      w_mant = c_hidden;
      w_exp  = r_s1_exp + c_exp_one;
    end else if ((r_s1_exp == '0) && w_inc_sum[MAN_W-1]) begin
      w_exp  = c_exp_one;
    end
  end

  assign w_ovf    = (&w_exp) && !r_s1_special;
  assign w_result = w_ovf ? {r_s1_sign, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}}
                          : {r_s1_sign, w_exp, w_mant[MAN_W-2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_inexact  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result   <= w_result;
        r_inexact  <= r_s1_inexact | w_ovf;
        r_overflow <= w_ovf;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_fp_round_norm.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_round_norm
// Purpose  : Scoreboard bench: directed rounding vectors, backpressure, reset.
// Revision : 1.0 - initial release
// ============================================================================

module tb_fp_round_norm;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_mant;
  logic [2:0]  in_grs;
  logic [1:0]  in_rm;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_inexact, out_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] res;
    logic        inx;
    logic        ovf;
    int          cyc;
    bit          lat;
  } exp_t;
  exp_t sb[$];

  fp_round_norm #(.EXP_W(8), .MAN_W(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_grs(in_grs), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_inexact(out_inexact), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: pops one expectation per output transfer
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h expected none", out_result);
        end else begin
          e = sb.pop_front();
          check("result", out_result, e.res);
          check("inexact", 32'(out_inexact), 32'(e.inx));
          check("overflow", 32'(out_overflow), 32'(e.ovf));
          if (e.lat) check("latency", 32'(cyc - e.cyc), 32'd2);
        end
      end
    end
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [23:0] m,
                      input logic [2:0] g, input logic [1:0] rm,
                      input logic [31:0] r, input logic inx, input logic ovf, input bit lat);
    bit done = 0;
    exp_t x;
    @(negedge clk);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_grs = g; in_rm = rm;
    for (int t = 0; t < 200; t++) begin
      #1;
      if (in_ready) begin
        x.res = r; x.inx = inx; x.ovf = ovf; x.cyc = cyc; x.lat = lat;
        sb.push_back(x);
        done = 1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && sb.size() != 0; t++) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    in_grs = '0; in_rm = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", out_result, 32'h0);
    check("rst_inexact", 32'(out_inexact), 32'd0);
    check("rst_overflow", 32'(out_overflow), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Directed rounding vectors, full rate
    send(0, 8'h7F, 24'h800000, 3'b100, 2'b00, 32'h3F800000, 1, 0, 1);
    send(0, 8'h7F, 24'h800001, 3'b100, 2'b00, 32'h3F800002, 1, 0, 1);
    send(0, 8'h7F, 24'hFFFFFF, 3'b110, 2'b00, 32'h40000000, 1, 0, 1);
    send(0, 8'h7F, 24'hFFFFFF, 3'b110, 2'b01, 32'h3FFFFFFF, 1, 0, 1);
    send(0, 8'hFE, 24'hFFFFFF, 3'b100, 2'b00, 32'h7F800000, 1, 1, 1);
    send(0, 8'hFE, 24'hFFFFFF, 3'b100, 2'b01, 32'h7F7FFFFF, 1, 0, 1);
    send(1, 8'hFE, 24'hFFFFFF, 3'b100, 2'b10, 32'hFF7FFFFF, 1, 0, 1);
    send(0, 8'h00, 24'h7FFFFF, 3'b111, 2'b00, 32'h00800000, 1, 0, 1);
    send(0, 8'hFF, 24'hC00000, 3'b111, 2'b10, 32'h7FC00000, 0, 0, 1);
    send(0, 8'h00, 24'h000000, 3'b100, 2'b10, 32'h00000001, 1, 0, 1);
    send(1, 8'h80, 24'h800000, 3'b001, 2'b11, 32'hC0000001, 1, 0, 1);
    send(0, 8'h80, 24'h800000, 3'b001, 2'b11, 32'h40000000, 1, 0, 1);
    send(0, 8'h80, 24'h800000, 3'b001, 2'b10, 32'h40000001, 1, 0, 1);
    send(0, 8'h80, 24'h800000, 3'b101, 2'b00, 32'h40000001, 1, 0, 1);
    send(0, 8'h80, 24'h800000, 3'b011, 2'b00, 32'h40000000, 1, 0, 1);
    send(0, 8'h80, 24'h800000, 3'b000, 2'b00, 32'h40000000, 0, 0, 1);
    drain();

    // Backpressure: two beats fill the pipe, output must hold
    @(negedge clk); out_ready = 1'b0;
    for (int i = 0; i < 2; i++)
      send(0, 8'h90 + 8'(i), 24'h800000 + 24'(i * 3), 3'b000, 2'b01,
           {1'b0, 8'h90 + 8'(i), 23'(i * 3)}, 0, 0, 0);
    @(negedge clk); #1;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    held = out_result;
    check("bp_head_value", held, 32'h48000000);
    repeat (4) @(negedge clk);
    #1;
    check("bp_stable", out_result, held);
    @(negedge clk); out_ready = 1'b1;
    for (int i = 2; i < 5; i++)
      send(0, 8'h90 + 8'(i), 24'h800000 + 24'(i * 3), 3'b000, 2'b01,
           {1'b0, 8'h90 + 8'(i), 23'(i * 3)}, 0, 0, 0);
    drain();

    // Reset mid-stream discards in-flight beats
    @(negedge clk); out_ready = 1'b0;
    send(0, 8'hA0, 24'h800000, 3'b000, 2'b00, 32'h50000000, 0, 0, 0);
    send(0, 8'hA1, 24'h800000, 3'b000, 2'b00, 32'h50800000, 0, 0, 0);
    @(negedge clk); #3;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", out_result, 32'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk); #1;
    check("ready_after_midrst", 32'(in_ready), 32'd1);
    check("no_stale_valid", 32'(out_valid), 32'd0);
    send(1, 8'h81, 24'h800003, 3'b100, 2'b00, 32'hC0800004, 1, 0, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
